timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_pkg.sv | 37 +++
 rtl/tick_gen.sv | 43 ++++
 rtl/timer_sched.sv | 102 ++++++++++
 tb/tb_timer_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler.
//   state_t  : controller states (IDLE, RUN, DONE)
//   ch_t     : channel index type
//   rr_pick  : round-robin channel search starting at a pointer
//   onehot   : channel index to one-hot channel vector
package timer_pkg;

  localparam int CH_NUM = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [CH_W-1:0] ch_t;

  // Lowest offset from ptr (with wrap) whose request bit is set wins.
  // Walking offsets from high to low lets the smallest offset overwrite last.
  // The result is only meaningful when at least one req bit is set.
  function automatic ch_t rr_pick(input logic [CH_NUM-1:0] req, input ch_t ptr);
    ch_t idx;
    ch_t pick;
    pick = ptr;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      idx = ptr + ch_t'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [CH_NUM-1:0] onehot(input ch_t c);
    return CH_NUM'(1) << c;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Time base: free-running modulo-DIV counter that is held at zero while clr
// is high and emits a one-cycle tick in the cycle the count equals DIV-1.
//   clk   : clock
//   reset : asynchronous active-high reset
//   clr   : synchronous clear; holds the counter at 0 and tick low
//   tick  : registered pulse, high while the counter equals DIV-1
module tick_gen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int         W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
  end

  // tick is registered alongside the counter so it is high exactly while
  // cnt == LAST, without a combinational compare on the output.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Round-robin timer scheduler. Grants one requesting channel at a time,
// times its duration in ticks of an internal time base, then signals done.
//   clk       : clock
//   reset     : asynchronous active-high reset
//   req       : per-channel request level, held until ack
//   dur       : per-channel duration in ticks, 8 bits per channel
//   abort     : single-cycle pulse cancelling the running timer
//   ack       : one-hot pulse, request accepted
//   done      : one-hot pulse, timer expired
//   busy      : high while running or finishing
//   active_ch : last granted channel
//   tick      : time-base pulse (low outside RUN)
module timer_sched
  import timer_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int NCH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [8*NCH-1:0] dur,
  input  logic             abort,
  output logic [NCH-1:0]   ack,
  output logic [NCH-1:0]   done,
  output logic             busy,
  output ch_t              active_ch,
  output logic             tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;

  state_t     state;
  state_t     state_nx;
  ch_t        ptr;
  ch_t        grant;
  logic [7:0] remaining;
  logic       clr;

  // The counter runs only across consecutive RUN cycles: it is cleared on the
  // grant edge and on the edge leaving RUN, so tick never shows outside RUN.
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    grant    = rr_pick(req, ptr);
    unique case (state)
      IDLE: if (|req) state_nx = RUN;
      RUN: begin
        // abort is tested first so it beats a coincident terminal tick
        if (abort)                          state_nx = IDLE;
        else if (remaining == 8'd0)         state_nx = DONE;
        else if (tick && remaining == 8'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    clr = !(state == RUN && state_nx == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      ack       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      active_ch <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      ack   <= '0;
      done  <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            ack       <= onehot(grant);
            active_ch <= grant;
            remaining <= dur[{grant, 3'b000} +: 8];
          end
        end
        RUN: begin
          if (!abort && tick && remaining != 8'd0) remaining <= remaining - 8'd1;
          // Leaving RUN by completion or abort both move the pointer on.
          if (state_nx != RUN) ptr <= ch_t'(active_ch + 1'b1);
        end
        DONE:    done <= onehot(active_ch);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with DIV = 8 (CLK_FREQ=8, TICK_HZ=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dur;
  logic        abort;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  active_ch;
  logic        tick;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  timer_sched #(.CLK_FREQ(8), .TICK_HZ(1), .NCH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .dur       (dur),
    .abort     (abort),
    .ack       (ack),
    .done      (done),
    .busy      (busy),
    .active_ch (active_ch),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Steps up to budget cycles; offsets are counted from the current cycle.
  // Returns at the first done pulse (done_off = -1 if none was seen).
  task automatic watch(input int budget, output int done_off, output logic [3:0] done_val,
                       output int nticks, output int t_first, output int t_last);
    done_off = -1;
    done_val = '0;
    nticks   = 0;
    t_first  = -1;
    t_last   = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if ((|ack) && (|done)) overlap++;
      if (tick) begin
        nticks++;
        if (t_first < 0) t_first = i;
        t_last = i;
      end
      if (done != 4'b0) begin
        done_off = i;
        done_val = done;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    abort = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  int         d_off;
  logic [3:0] d_val;
  int         nt;
  int         tf;
  int         tl;

  initial begin
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    abort = 1'b0;
    step();
    check("reset_outputs", {20'd0, ack, done, busy, active_ch, tick}, 32'd0);
    reset = 1'b0;

    // Single channel, dur0 = 3: ticks at offsets 7/15/23, done at 25.
    dur = 32'h0000_0003;
    req = 4'b0001;
    step();
    check("t1_ack", ack, 4'b0001);
    check("t1_busy", busy, 1);
    req = 4'b0000;
    watch(40, d_off, d_val, nt, tf, tl);
    check("t1_done_off", d_off, 25);
    check("t1_done_val", d_val, 4'b0001);
    check("t1_nticks", nt, 3);
    check("t1_first_tick", tf, 7);
    check("t1_tick_span", tl - tf, 16);
    check("t1_busy_at_done", busy, 0);

    // All four requesting, dur=1 each: round-robin order 0,1,2,3.
    do_reset();
    dur = 32'h0101_0101;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t2_ack%0d", k), ack, 4'(1) << k);
      check($sformatf("t2_ch%0d", k), active_ch, k);
      watch(20, d_off, d_val, nt, tf, tl);
      check($sformatf("t2_done_off%0d", k), d_off, 9);
      check($sformatf("t2_done_val%0d", k), d_val, 4'(1) << k);
    end
    req = 4'b0000;

    // dur2 = 0: done two cycles after ack, no tick at all.
    dur = 32'h0000_0000;
    req = 4'b0100;
    step();
    check("t3_ack", ack, 4'b0100);
    req = 4'b0000;
    watch(20, d_off, d_val, nt, tf, tl);
    check("t3_done_off", d_off, 2);
    check("t3_done_val", d_val, 4'b0100);
    check("t3_nticks", nt, 0);
    step();
    check("t3_active_hold", active_ch, 2);

    // dur1 = 5, abort 20 cycles after ack, then a normal grant of ch1.
    dur = 32'h0000_0500;
    req = 4'b0010;
    step();
    check("t4_ack", ack, 4'b0010);
    req = 4'b0000;
    repeat (20) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy_after_abort", busy, 0);
    check("t4_done_after_abort", done, 4'b0000);
    watch(50, d_off, d_val, nt, tf, tl);
    check("t4_no_done", d_off, -1);
    check("t4_no_tick", nt, 0);
    req = 4'b0010;
    step();
    check("t4_reack", ack, 4'b0010);
    req = 4'b0000;
    watch(60, d_off, d_val, nt, tf, tl);
    check("t4_done_off", d_off, 41);
    check("t4_nticks", nt, 5);

    // Asynchronous reset in the middle of a run.
    dur = 32'h0000_0003;
    req = 4'b0001;
    step();
    check("t5_ack", ack, 4'b0001);
    req = 4'b0000;
    repeat (10) step();
    check("t5_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1 check("t5_async_reset", {20'd0, ack, done, busy, active_ch, tick}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    watch(40, d_off, d_val, nt, tf, tl);
    check("t5_no_done", d_off, -1);

    // dur0 = 1, abort lands on the terminal-tick cycle: abort wins.
    dur = 32'h0000_0001;
    req = 4'b0001;
    step();
    check("t6_ack", ack, 4'b0001);
    req = 4'b0000;
    repeat (7) step();
    check("t6_tick", tick, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_busy", busy, 0);
    watch(30, d_off, d_val, nt, tf, tl);
    check("t6_no_done", d_off, -1);
    req = 4'b0001;
    step();
    check("t6_reack", ack, 4'b0001);
    req = 4'b0000;
    watch(20, d_off, d_val, nt, tf, tl);
    check("t6_done_off", d_off, 9);

    check("ack_done_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
